// File: rtl/seg_scanner_pkg.sv
// seg_scanner_pkg: shared constants and types for the hex segment scanner.
// Glyphs are active-low, ordered {g,f,e,d,c,b,a} (bit 6 = g, bit 0 = a).
package seg_scanner_pkg;

    // Segment bit positions inside the 7-bit pattern.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-low hex glyphs.
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    // All segments dark.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Phase within one digit slot.
    typedef enum logic {
        BLANK  = 1'b0,
        ACTIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_hex_glyph.sv
// seg_hex_glyph: combinational nibble to active-low seven-segment decoder.
module seg_hex_glyph
    import seg_scanner_pkg::*;
(
    input  logic [3:0]           nibble,
    output logic [SEG_G:SEG_A]   segments
);

    // Map each hex nibble to its glyph.
    always_comb begin
        // NOTE: default assignment first so every path drives segments and no latch is inferred.
        segments = SEG_BLANK;
        case (nibble)
            4'h0: segments = GLYPH_0;
            4'h1: segments = GLYPH_1;
            4'h2: segments = GLYPH_2;
            4'h3: segments = GLYPH_3;
            4'h4: segments = GLYPH_4;
            4'h5: segments = GLYPH_5;
            4'h6: segments = GLYPH_6;
            4'h7: segments = GLYPH_7;
            4'h8: segments = GLYPH_8;
            4'h9: segments = GLYPH_9;
            4'hA: segments = GLYPH_A;
            4'hB: segments = GLYPH_B;
            4'hC: segments = GLYPH_C;
            4'hD: segments = GLYPH_D;
            4'hE: segments = GLYPH_E;
            4'hF: segments = GLYPH_F;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/segment_led_hex_scanner.sv
// segment_led_hex_scanner: multiplexed driver for a bank of common-anode hex
// digits on a shared segment bus, with per-slot blanking and a double-buffered
// value register so a frame never mixes old and new digits.
// Build option: define SEG_SCANNER_LEADING_ZERO_BLANK_EN to blank leading zeros.
module segment_led_hex_scanner
    import seg_scanner_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic [4*DIGITS-1:0]   Value,
    input  logic                  Load,
    input  logic [DIGITS-1:0]     DecimalPoints,
    output logic [6:0]            Segments,
    output logic                  Dp,
    output logic [DIGITS-1:0]     Anodes,
    output logic                  FrameStart
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    // A slot opens in BLANK unless blanking is configured away.
    localparam scan_state_e FIRST_STATE = (BLANK_CYCLES > 0) ? BLANK : ACTIVE;

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    scan_state_e         state;
    logic                slot_end;
    logic                frame_end;
    logic                frame_pulse;
    logic [4*DIGITS-1:0] shadow_val;
    logic [4*DIGITS-1:0] disp_val;
    logic [DIGITS-1:0]   shadow_dp;
    logic [DIGITS-1:0]   disp_dp;
    logic [3:0]          cur_nibble;
    logic [6:0]          cur_glyph_raw;
    logic [6:0]          cur_glyph;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Slot counter, digit index and BLANK/ACTIVE phase of the current slot.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            cnt   <= '0;
            idx   <= '0;
            state <= FIRST_STATE;
        end else if (slot_end) begin
            cnt   <= '0;
            idx   <= frame_end ? '0 : idx + IW'(1);
            state <= FIRST_STATE;
        end else begin
            cnt <= cnt + CW'(1);
            if (state == BLANK && int'(cnt) == BLANK_CYCLES - 1) begin
                state <= ACTIVE;
            end
        end
    end

    // Double buffer: Load fills shadow, each frame boundary publishes shadow.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
        end else begin
            if (Load) begin
                shadow_val <= Value;
                shadow_dp  <= DecimalPoints;
            end
            if (frame_end) begin
                disp_val <= shadow_val;
                disp_dp  <= shadow_dp;
            end
        end
    end

    // Select the nibble of the digit currently being scanned.
    always_comb begin
        cur_nibble = disp_val[{idx, 2'b00} +: 4];
    end

    seg_hex_glyph u_glyph (
        .nibble   (cur_nibble),
        .segments (cur_glyph_raw)
    );

`ifdef SEG_SCANNER_LEADING_ZERO_BLANK_EN
    logic [IW-1:0] msd;

    // Highest nonzero digit; digit 0 counts as significant even when zero.
    always_comb begin
        msd = '0;
        for (int k = 1; k < DIGITS; k++) begin
            if (disp_val[4*k +: 4] != 4'h0) begin
                msd = IW'(k);
            end
        end
    end

    assign cur_glyph = (idx > msd) ? SEG_BLANK : cur_glyph_raw;
`else
    assign cur_glyph = cur_glyph_raw;
`endif

    // Registered pin drivers, one cycle behind the counter/index.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            Anodes      <= '1;
            Segments    <= SEG_BLANK;
            Dp          <= 1'b1;
            FrameStart  <= 1'b0;
            frame_pulse <= 1'b0;
        end else begin
            frame_pulse <= frame_end;
            FrameStart  <= frame_pulse;
            if (state == BLANK) begin
                Anodes   <= '1;
                Segments <= SEG_BLANK;
                Dp       <= 1'b1;
            end else begin
                Anodes   <= ~(DIGITS'(1) << idx);
                Segments <= cur_glyph;
                Dp       <= ~disp_dp[idx];
            end
        end
    end

endmodule

// File: tb/tb_segment_led_hex_scanner.sv
// tb_segment_led_hex_scanner: scoreboard bench for the hex segment scanner.
// Instance a: 4 digits, 8-cycle slots, 2 blank cycles. Instance b: 1 digit, 5-cycle slots, no blanking.
module tb_segment_led_hex_scanner;

    localparam int DA = 4;
    localparam int RA = 8;
    localparam int BA = 2;
    localparam int FRAME_A = DA * RA;
    localparam int RB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, load_a;
    logic [15:0] value_a;
    logic [3:0]  dps_a;
    logic [6:0]  seg_a;
    logic        dp_a;
    logic [3:0]  an_a;
    logic        fs_a;

    logic        rst_b, load_b;
    logic [3:0]  value_b;
    logic [0:0]  dps_b;
    logic [6:0]  seg_b;
    logic        dp_b;
    logic [0:0]  an_b;
    logic        fs_b;

    segment_led_hex_scanner #(.DIGITS(DA), .REFRESH_DIV(RA), .BLANK_CYCLES(BA)) dut_a (
        .Clock(clk), .ResetN(rst_a), .Value(value_a), .Load(load_a),
        .DecimalPoints(dps_a), .Segments(seg_a), .Dp(dp_a), .Anodes(an_a), .FrameStart(fs_a)
    );

    segment_led_hex_scanner #(.DIGITS(1), .REFRESH_DIV(RB), .BLANK_CYCLES(0)) dut_b (
        .Clock(clk), .ResetN(rst_b), .Value(value_b), .Load(load_b),
        .DecimalPoints(dps_b), .Segments(seg_b), .Dp(dp_b), .Anodes(an_b), .FrameStart(fs_b)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } obs_t;

    int vectors = 0;
    int miscompares = 0;

    obs_t sb_a[$];
    obs_t sb_b[$];
    int   k_a, k_b;                 // clock edges since reset release
    logic [15:0] shadow_m, disp_m;
    logic [3:0]  sdp_m, ddp_m;
    logic [3:0]  shadow_bm, disp_bm;
    logic        sdp_bm, ddp_bm;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    // Expected pins of instance a for output sample n (n = edges since release - 1).
    function automatic obs_t model_a(input int n, input logic [15:0] v, input logic [3:0] dps);
        obs_t e;
        int pos, slot;
        pos  = n % RA;
        slot = (n / RA) % DA;
        e.fs = (n >= FRAME_A) && (n % FRAME_A == 0);
        if (pos < BA) begin
            e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
        end else begin
            e.an = 4'hF;
            e.an[slot] = 1'b0;
            e.seg = glyph(v[slot*4 +: 4]);
`ifdef SEG_SCANNER_LEADING_ZERO_BLANK_EN
            if (slot > 0 && (v >> (4 * slot)) == 16'h0) e.seg = 7'h7F;
`endif
            e.dp = ~dps[slot];
        end
        return e;
    endfunction

    // Drive one cycle on instance a and push the expected pins for the next sample.
    task automatic step_a(input logic ld, input logic [15:0] val, input logic [3:0] dps);
        load_a = ld; value_a = val; dps_a = dps;
        k_a++;
        sb_a.push_back(model_a(k_a - 1, disp_m, ddp_m));
        if (k_a % FRAME_A == 0) begin disp_m = shadow_m; ddp_m = sdp_m; end
        if (ld) begin shadow_m = val; sdp_m = dps; end
        @(negedge clk);
        load_a = 1'b0;
    endtask

    task automatic restart_a_model();
        k_a = 0; shadow_m = '0; disp_m = '0; sdp_m = '0; ddp_m = '0;
        sb_a.delete();
    endtask

    task automatic test_reset();
        obs_t got, exp;
        rst_a = 1'b1; rst_b = 1'b1; load_a = 0; load_b = 0;
        value_a = '0; dps_a = '0; value_b = '0; dps_b = '0;
        #1 rst_a = 1'b0; rst_b = 1'b0;
        #1;
        vectors++;
        if ({an_a, seg_a, dp_a, fs_a} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: an=%h seg=%h dp=%b fs=%b, want an=f seg=7f dp=1 fs=0", an_a, seg_a, dp_a, fs_a);
        end
        @(negedge clk);
        rst_a = 1'b1;
        restart_a_model();
        for (int i = 0; i < 12; i++) begin
            step_a(1'b0, 16'h0, 4'h0);
            got = {an_a, seg_a, dp_a, fs_a}; exp = sb_a.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_run n=%0d: got %h, want %h", k_a - 1, got, exp);
            end
        end
        // Sample n=11 is digit 1 ACTIVE; pull reset asynchronously mid-slot.
        #2 rst_a = 1'b0;
        #1;
        vectors++;
        if ({an_a, seg_a, dp_a, fs_a} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: an=%h seg=%h dp=%b fs=%b, want an=f seg=7f dp=1 fs=0", an_a, seg_a, dp_a, fs_a);
        end
        @(negedge clk);
        rst_a = 1'b1;
        restart_a_model();
        for (int i = 0; i < 4; i++) begin
            step_a(1'b0, 16'h0, 4'h0);
            got = {an_a, seg_a, dp_a, fs_a}; exp = sb_a.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL post_reset n=%0d: got %h, want %h", k_a - 1, got, exp);
            end
            if (i == 2) begin
                vectors++;
                if (an_a !== 4'hE) begin
                    miscompares++;
                    $display("FAIL first_active: anodes %h, want e", an_a);
                end
            end
        end
    endtask

    task automatic test_scan();
        obs_t got, exp;
        logic [6:0] want_seg [4];
        logic [3:0] want_an [4];
        int n;
        want_seg = '{7'h0E, 7'h30, 7'h08, 7'h79};
        want_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
        step_a(1'b1, 16'h1A3F, 4'b0100);
        got = {an_a, seg_a, dp_a, fs_a}; exp = sb_a.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL scan n=%0d: got %h, want %h", k_a - 1, got, exp);
        end
        while (k_a < 3 * FRAME_A) begin
            step_a(1'b0, 16'h0, 4'h0);
            n = k_a - 1;
            got = {an_a, seg_a, dp_a, fs_a}; exp = sb_a.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL scan n=%0d: got %h, want %h", n, got, exp);
            end
            // Fixed spot checks in the first frame showing 1A3F.
            if (n >= FRAME_A && n < 2 * FRAME_A && (n % RA) == 3) begin
                vectors++;
                if (seg_a !== want_seg[(n / RA) % DA] || an_a !== want_an[(n / RA) % DA] ||
                    dp_a !== ((n / RA) % DA != 2)) begin
                    miscompares++;
                    $display("FAIL scan_digit%0d: seg=%h an=%h dp=%b, want seg=%h an=%h dp=%b",
                             (n / RA) % DA, seg_a, an_a, dp_a, want_seg[(n / RA) % DA],
                             want_an[(n / RA) % DA], ((n / RA) % DA != 2));
                end
            end
        end
    endtask

    task automatic test_boundary_load();
        obs_t got, exp;
        int fs_count, base;
        while ((k_a + 1) % FRAME_A != 0) begin
            step_a(1'b0, 16'h0, 4'h0);
            got = {an_a, seg_a, dp_a, fs_a}; exp = sb_a.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL boundary_pre n=%0d: got %h, want %h", k_a - 1, got, exp);
            end
        end
        step_a(1'b1, 16'h0050, 4'b0001);   // Load sampled on the wrap edge
        got = {an_a, seg_a, dp_a, fs_a}; exp = sb_a.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL boundary_load n=%0d: got %h, want %h", k_a - 1, got, exp);
        end
        base = k_a;
        fs_count = 0;
        for (int i = 0; i < 2 * FRAME_A; i++) begin
            step_a(1'b0, 16'h0, 4'h0);
            fs_count += int'(fs_a);
            got = {an_a, seg_a, dp_a, fs_a}; exp = sb_a.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL boundary n=%0d: got %h, want %h", k_a - 1, got, exp);
            end
            if (k_a - base == 3) begin
                vectors++;
                if (seg_a !== 7'h0E || dp_a !== 1'b1) begin
                    miscompares++;
                    $display("FAIL boundary_old_frame: seg=%h dp=%b, want seg=0e dp=1", seg_a, dp_a);
                end
            end
            if (k_a - base == FRAME_A + 3) begin
                vectors++;
                if (seg_a !== 7'h40 || dp_a !== 1'b0) begin
                    miscompares++;
                    $display("FAIL boundary_new_frame: seg=%h dp=%b, want seg=40 dp=0", seg_a, dp_a);
                end
            end
        end
        vectors++;
        if (fs_count != 2) begin
            miscompares++;
            $display("FAIL frame_start_count: %0d pulses, want 2", fs_count);
        end
    endtask

    task automatic test_leading_zero();
        obs_t got, exp;
        // 0050 is on display now; load 0000 and watch it through the next frame.
        step_a(1'b1, 16'h0000, 4'h0);
        got = {an_a, seg_a, dp_a, fs_a}; exp = sb_a.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL leading_zero n=%0d: got %h, want %h", k_a - 1, got, exp);
        end
        for (int i = 0; i < 2 * FRAME_A; i++) begin
            step_a(1'b0, 16'h0, 4'h0);
            got = {an_a, seg_a, dp_a, fs_a}; exp = sb_a.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL leading_zero n=%0d: got %h, want %h", k_a - 1, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, exp;
        step_a(1'b1, 16'hBEEF, 4'b1010);
        got = {an_a, seg_a, dp_a, fs_a}; exp = sb_a.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL back_to_back n=%0d: got %h, want %h", k_a - 1, got, exp);
        end
        step_a(1'b1, 16'hC0DE, 4'b0011);
        got = {an_a, seg_a, dp_a, fs_a}; exp = sb_a.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL back_to_back n=%0d: got %h, want %h", k_a - 1, got, exp);
        end
        for (int i = 0; i < 2 * FRAME_A; i++) begin
            step_a(1'b0, 16'h0, 4'h0);
            got = {an_a, seg_a, dp_a, fs_a}; exp = sb_a.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL back_to_back n=%0d: got %h, want %h", k_a - 1, got, exp);
            end
        end
    endtask

    task automatic test_single_digit();
        obs_t got, exp;
        vectors++;
        if ({an_b, seg_b, dp_b, fs_b} !== {1'b1, 7'h7F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL single_reset: an=%b seg=%h dp=%b fs=%b, want an=1 seg=7f dp=1 fs=0", an_b, seg_b, dp_b, fs_b);
        end
        rst_b = 1'b1;
        k_b = 0; shadow_bm = '0; disp_bm = '0; sdp_bm = 1'b0; ddp_bm = 1'b0;
        for (int i = 0; i < 4 * RB; i++) begin
            load_b = (i == 0); value_b = 4'h7; dps_b = 1'b1;
            k_b++;
            exp.an  = 4'h0;
            exp.seg = glyph(disp_bm);
            exp.dp  = ~ddp_bm;
            exp.fs  = (k_b - 1 >= RB) && ((k_b - 1) % RB == 0);
            sb_b.push_back(exp);
            if (k_b % RB == 0) begin disp_bm = shadow_bm; ddp_bm = sdp_bm; end
            if (i == 0) begin shadow_bm = 4'h7; sdp_bm = 1'b1; end
            @(negedge clk);
            load_b = 1'b0;
            got = {3'b000, an_b, seg_b, dp_b, fs_b}; exp = sb_b.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL single_digit n=%0d: got %h, want %h", k_b - 1, got, exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scan();
        test_boundary_load();
        test_leading_zero();
        test_back_to_back();
        test_single_digit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
